// File: rtl/blink_pkg.sv
// ============================================================================
//  blink_pkg : shared state encoding and default sizing for the LED blink
//              scheduler
//  Rev 1.0
// ============================================================================
`default_nettype none

package blink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int c_CLK_DIV  = 25000;
    localparam int c_PERIOD_W = 16;
    localparam int c_COUNT_W  = 8;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
//  tick_prescaler : free-running divider that emits a one-cycle tick every
//                   CLK_DIV enabled cycles; synchronous clear wins over enable
//  Rev 1.0
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int                 c_CNT_W = $clog2(CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == c_MAX) ? '0 : cnt_q + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == c_MAX);

endmodule

`default_nettype wire

// File: rtl/blink_sched_ctrl.sv
// ============================================================================
//  blink_sched_ctrl : command-driven LED blink sequencer; accepts
//                     {half-period, blink-count} and toggles oLEDR accordingly
//  Rev 1.0
// ============================================================================
`default_nettype none

module blink_sched_ctrl
    import blink_pkg::*;
#(
    parameter int CLK_DIV  = c_CLK_DIV,
    parameter int PERIOD_W = c_PERIOD_W,
    parameter int COUNT_W  = c_COUNT_W
) (
    input  logic                iCLK_50,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [PERIOD_W-1:0] cmd_half_period,
    input  logic [COUNT_W-1:0]  cmd_blinks,
    input  logic                abort,
    output logic                oLEDR,
    output logic                busy,
    output logic                done
);

    state_t              state_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] half_cnt_q;
    logic [COUNT_W-1:0]  rem_q;
    logic                led_q;
    logic                busy_q;
    logic                done_q;
    logic                ready_q;

    logic tick;
    logic cmd_accept;
    logic half_last;
    logic blink_end;
    logic last_blink;

    assign cmd_accept = (state_q == IDLE) && cmd_valid && ready_q;

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk  (iCLK_50),
        .rst  (rst),
        .clr  (cmd_accept),
        .en   (state_q == RUN),
        .tick (tick)
    );

    // A blink ends with its low half, so the closing edge is the one that
    // would otherwise raise the LED again. rem_q==0 marks continuous mode.
    assign half_last  = (half_cnt_q == period_q - PERIOD_W'(1));
    assign blink_end  = tick && half_last && !led_q;
    assign last_blink = blink_end && (rem_q == COUNT_W'(1));

    always_ff @(posedge iCLK_50) begin
        if (rst) begin
            state_q    <= IDLE;
            period_q   <= '0;
            half_cnt_q <= '0;
            rem_q      <= '0;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_accept) begin
                        period_q   <= (cmd_half_period == '0) ? PERIOD_W'(1)
                                                              : cmd_half_period;
                        rem_q      <= cmd_blinks;
                        half_cnt_q <= '0;
                        led_q      <= 1'b1;
                        busy_q     <= 1'b1;
                        ready_q    <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (abort || last_blink) begin
                        led_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (tick) begin
                        if (half_last) begin
                            half_cnt_q <= '0;
                            led_q      <= ~led_q;
                            if (blink_end && (rem_q != '0)) begin
                                rem_q <= rem_q - COUNT_W'(1);
                            end
                        end else begin
                            half_cnt_q <= half_cnt_q + PERIOD_W'(1);
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    led_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign oLEDR     = led_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

`default_nettype wire
